// File: rtl/bus_pkg.sv
// Shared CPU-bus types: FSM states, request tuple, decode defaults.
// Imported by the responder and future bus targets.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } bus_state_t;

  localparam logic [15:0] RAM_WINDOW_END_DEFAULT = 16'h1FFF;
  localparam int RAM_BYTES_DEFAULT = 2048;

  typedef struct packed {
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [7:0]  wdata;
  } bus_request_t;

  // Write data only distinguishes tuples that are writes.
  function automatic logic req_match(
    bus_request_t a,
    bus_request_t b
  );
    return (a.addr == b.addr) &&
           (a.rd == b.rd) &&
           (a.wr == b.wr) &&
           (!a.wr || (a.wdata == b.wdata));
  endfunction

endpackage

// File: rtl/ram_bus_responder_if.sv
// CPU bus signals between initiator (master) and target (slave).
// Request: address/data/read/write; response: data_o/data_valid_o.
interface ram_bus_responder_if;
  logic [15:0] address_i;
  logic [7:0]  data_i;
  logic        bus_read_i;
  logic        bus_write_i;
  logic [7:0]  data_o;
  logic        data_valid_o;

  modport master (
    output address_i, data_i,
    output bus_read_i, bus_write_i,
    input  data_o, data_valid_o
  );

  modport slave (
    input  address_i, data_i,
    input  bus_read_i, bus_write_i,
    output data_o, data_valid_o
  );
endinterface

// File: rtl/bus_ram.sv
// Single-port synchronous byte RAM, registered read, write enable.
// Ports: clk, addr_i, wdata_i, we_i, re_i, rdata_o.
module bus_ram #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            wdata_i,
  input  logic                  we_i,
  input  logic                  re_i,
  output logic [7:0]            rdata_o
);
  logic [7:0] mem [2**ADDR_WIDTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end else if (re_i) begin
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/ram_bus_responder.sv
// Bus target backing mirrored work RAM with programmable wait states.
// Ports: clock_i, reset_i (async, active-high), bus (slave modport).
module ram_bus_responder
  import bus_pkg::*;
#(
  parameter int          RAM_ADDR_WIDTH = 11,
  parameter int          WAIT_CYCLES    = 2,
  parameter logic [15:0] RAM_WINDOW_END = RAM_WINDOW_END_DEFAULT
) (
  input logic                 clock_i,
  input logic                 reset_i,
  ram_bus_responder_if.slave  bus
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be within 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  bus_state_t   state_q, state_d;
  bus_request_t cap_q, cap_d;
  bus_request_t req;
  logic [3:0]   cnt_q, cnt_d;
  logic [7:0]   open_q, open_d;
  logic [7:0]   ram_rdata;
  logic         active, same, fire;
  logic         cap_hit, rd_hit;
  logic         ram_we, ram_re;

  assign req.addr  = bus.address_i;
  assign req.rd    = bus.bus_read_i;
  assign req.wr    = bus.bus_write_i;
  assign req.wdata = bus.data_i;

  assign active  = req.rd | req.wr;
  assign same    = req_match(req, cap_q);
  assign fire    = (state_q == WAIT) && same &&
                   (cnt_q == 4'd0);
  assign cap_hit = cap_q.addr <= RAM_WINDOW_END;
  assign rd_hit  = cap_q.rd && cap_hit;

  // Read wins over a simultaneous write.
  assign ram_we = fire && cap_q.wr &&
                  !cap_q.rd && cap_hit;
  assign ram_re = fire && rd_hit;

  bus_ram #(
    .ADDR_WIDTH (RAM_ADDR_WIDTH)
  ) u_ram (
    .clk     (clock_i),
    .addr_i  (cap_q.addr[RAM_ADDR_WIDTH-1:0]),
    .wdata_i (cap_q.wdata),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    open_d  = open_q;
    unique case (state_q)
      IDLE: begin
        if (active) begin
          cap_d   = req;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!active) begin
          cap_d   = '0;
          state_d = IDLE;
        end else if (!same) begin
          cap_d = req;
          cnt_d = CNT_INIT;
        end else if (cnt_q == 4'd0) begin
          state_d = RESPOND;
          if (!cap_q.rd) open_d = cap_q.wdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESPOND: begin
        // RAM output is latched by now; fold it into open bus.
        if (rd_hit) open_d = ram_rdata;
        if (!active) begin
          cap_d   = '0;
          state_d = IDLE;
        end else if (!same) begin
          cap_d   = req;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      default: begin
        cap_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cap_q   <= '0;
      cnt_q   <= 4'd0;
      open_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      open_q  <= open_d;
    end
  end

  assign bus.data_valid_o = (state_q == RESPOND);
  assign bus.data_o = (state_q == RESPOND && rd_hit) ?
                      ram_rdata : open_q;

endmodule

// File: tb/tb_ram_bus_responder.sv
// Directed bench for ram_bus_responder: latency, mirror,
// write-once, open bus, restart, reset abort, read priority.
module tb_ram_bus_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int we_count = 0;

  ram_bus_responder_if bus ();

  ram_bus_responder dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (dut.u_ram.we_i === 1'b1) we_count++;

  task automatic drive(input logic [15:0] a, input logic r,
                       input logic w, input logic [7:0] d);
    bus.address_i   = a;
    bus.bus_read_i  = r;
    bus.bus_write_i = w;
    bus.data_i      = d;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(16'h0, 1'b0, 1'b0, 8'h00);
    step(2);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    drive(a, 1'b0, 1'b1, d);
    step(3);
    idle();
  endtask

  task automatic test_reset();
    drive(16'h0, 1'b0, 1'b0, 8'h00);
    #12;
    checks++;
    if (bus.data_valid_o !== 1'b0 || bus.data_o !== 8'h00) begin
      failures++;
      $display("FAIL reset: valid=%b data=%h want 0/00",
               bus.data_valid_o, bus.data_o);
    end
    @(negedge clk);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_read_latency();
    int bad;
    logic [2:0] v;
    wr(16'h0005, 8'h5A);
    drive(16'h0005, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(1);
      v[i] = bus.data_valid_o;
    end
    checks++;
    if (v !== 3'b100) begin
      failures++;
      $display("FAIL latency: valid seq=%b want 100", v);
    end
    checks++;
    if (bus.data_o !== 8'h5A) begin
      failures++;
      $display("FAIL read5: data=%h want 5a", bus.data_o);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus.data_valid_o !== 1'b1 || bus.data_o !== 8'h5A)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL hold: unstable cycles=%0d want 0", bad);
    end
    idle();
    checks++;
    if (bus.data_valid_o !== 1'b0 || bus.data_o !== 8'h5A) begin
      failures++;
      $display("FAIL idle_keep: valid=%b data=%h want 0/5a",
               bus.data_valid_o, bus.data_o);
    end
  endtask

  task automatic test_mirror();
    drive(16'h0123, 1'b0, 1'b1, 8'hA5);
    step(3);
    checks++;
    if (bus.data_valid_o !== 1'b1 || bus.data_o !== 8'hA5) begin
      failures++;
      $display("FAIL wr_ack: valid=%b data=%h want 1/a5",
               bus.data_valid_o, bus.data_o);
    end
    idle();
    wr(16'h0077, 8'h00);
    drive(16'h1923, 1'b1, 1'b0, 8'h00);
    step(3);
    checks++;
    if (bus.data_valid_o !== 1'b1 || bus.data_o !== 8'hA5) begin
      failures++;
      $display("FAIL mirror: valid=%b data=%h want 1/a5",
               bus.data_valid_o, bus.data_o);
    end
    idle();
    wr(16'h1000, 8'h99);
    drive(16'h0000, 1'b1, 1'b0, 8'h00);
    step(3);
    checks++;
    if (bus.data_o !== 8'h99) begin
      failures++;
      $display("FAIL alias1000: data=%h want 99", bus.data_o);
    end
    idle();
  endtask

  task automatic test_write_once();
    int base;
    base = we_count;
    drive(16'h0040, 1'b0, 1'b1, 8'h11);
    step(30);
    checks++;
    if (we_count - base !== 1) begin
      failures++;
      $display("FAIL write_once: writes=%0d want 1",
               we_count - base);
    end
    drive(16'h0040, 1'b0, 1'b1, 8'h22);
    step(10);
    checks++;
    if (we_count - base !== 2 || bus.data_o !== 8'h22) begin
      failures++;
      $display("FAIL rewrite: writes=%0d data=%h want 2/22",
               we_count - base, bus.data_o);
    end
    idle();
    drive(16'h0040, 1'b1, 1'b0, 8'h00);
    step(3);
    checks++;
    if (bus.data_o !== 8'h22) begin
      failures++;
      $display("FAIL read40: data=%h want 22", bus.data_o);
    end
    idle();
  endtask

  task automatic test_open_bus();
    int base;
    logic [2:0] v;
    wr(16'h0050, 8'h3C);
    drive(16'h0050, 1'b1, 1'b0, 8'h00);
    step(3);
    idle();
    drive(16'h8000, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(1);
      v[i] = bus.data_valid_o;
    end
    checks++;
    if (v !== 3'b100 || bus.data_o !== 8'h3C) begin
      failures++;
      $display("FAIL miss_read: valid seq=%b data=%h want 100/3c",
               v, bus.data_o);
    end
    idle();
    base = we_count;
    drive(16'h4000, 1'b0, 1'b1, 8'h77);
    step(3);
    checks++;
    if (bus.data_valid_o !== 1'b1 || bus.data_o !== 8'h77 ||
        we_count !== base) begin
      failures++;
      $display("FAIL miss_write: valid=%b data=%h writes=%0d want 1/77/0",
               bus.data_valid_o, bus.data_o, we_count - base);
    end
    idle();
    drive(16'hFFFC, 1'b1, 1'b0, 8'h00);
    step(3);
    checks++;
    if (bus.data_o !== 8'h77) begin
      failures++;
      $display("FAIL open_bus: data=%h want 77", bus.data_o);
    end
    idle();
    wr(16'h1FFF, 8'h42);
    wr(16'h2000, 8'h55);
    drive(16'h07FF, 1'b1, 1'b0, 8'h00);
    step(3);
    checks++;
    if (bus.data_o !== 8'h42) begin
      failures++;
      $display("FAIL window_edge: data=%h want 42", bus.data_o);
    end
    idle();
  endtask

  task automatic test_restart();
    logic [3:0] v;
    wr(16'h0001, 8'hB1);
    wr(16'h0002, 8'hB2);
    drive(16'h0001, 1'b1, 1'b0, 8'h00);
    step(1);
    v[0] = bus.data_valid_o;
    drive(16'h0002, 1'b1, 1'b0, 8'h00);
    for (int i = 1; i < 4; i++) begin
      step(1);
      v[i] = bus.data_valid_o;
    end
    checks++;
    if (v !== 4'b1000 || bus.data_o !== 8'hB2) begin
      failures++;
      $display("FAIL restart: valid seq=%b data=%h want 1000/b2",
               v, bus.data_o);
    end
    idle();
  endtask

  task automatic test_reset_mid_wait();
    int base;
    wr(16'h0010, 8'h10);
    base = we_count;
    drive(16'h0010, 1'b0, 1'b1, 8'hEE);
    step(1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.data_valid_o !== 1'b0 || bus.data_o !== 8'h00) begin
      failures++;
      $display("FAIL async_rst: valid=%b data=%h want 0/00",
               bus.data_valid_o, bus.data_o);
    end
    step(3);
    drive(16'h0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    step(1);
    drive(16'h0010, 1'b1, 1'b0, 8'h00);
    step(3);
    checks++;
    if (bus.data_o !== 8'h10 || we_count !== base) begin
      failures++;
      $display("FAIL abort: data=%h writes=%0d want 10/0",
               bus.data_o, we_count - base);
    end
    idle();
  endtask

  task automatic test_rd_wr();
    int base;
    base = we_count;
    drive(16'h0010, 1'b1, 1'b1, 8'hCC);
    step(3);
    checks++;
    if (bus.data_valid_o !== 1'b1 || bus.data_o !== 8'h10 ||
        we_count !== base) begin
      failures++;
      $display("FAIL rd_wins: valid=%b data=%h writes=%0d want 1/10/0",
               bus.data_valid_o, bus.data_o, we_count - base);
    end
    idle();
    drive(16'h0010, 1'b1, 1'b0, 8'h00);
    step(3);
    checks++;
    if (bus.data_o !== 8'h10) begin
      failures++;
      $display("FAIL rd_wins_ram: data=%h want 10", bus.data_o);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_mirror();
    test_write_once();
    test_open_bus();
    test_restart();
    test_reset_mid_wait();
    test_rd_wr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
